kbd_line_ctrl: RTL

Keyboard line controller between the PS/2 byte receiver and the processor/VGA text subsystem. It parses scan-code set 2 byte streams into key events, tracks shift state and edits a single command line buffer. Each edit is echoed to the shared text video RAM through a request/grant write port. A completed line, terminated by Enter, is handed to the processor with a ready/ack handshake.

---
 rtl/kbd_line_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/kbd_line_ctrl.sv
// kbd_line_ctrl
// Turns PS/2 scan-code set 2 bytes into key events, tracks shift state and
// edits a single command-line buffer. Each edit is echoed to the text video
// RAM through a request/grant port. Enter hands the finished line to the
// processor, which releases it with line_ack.
//
// Ports
//   CLK, reset            clock (rising edge) and synchronous active-high reset
//   rx_data/rx_valid      scan-code byte and its one-cycle strobe
//   rx_err                receiver error strobe; clears any pending prefix
//   vram_req/gnt/addr/    echo write request, grant, address and data
//   vram_data/vram_we     (vram_we = vram_req & vram_gnt)
//   line_ready/line_len   completed line available and its length
//   line_ack              processor has consumed the line
//   rd_addr/rd_data       combinational read port into the line buffer
//   overflow              one-cycle pulse when a character or byte is dropped
module kbd_line_ctrl #(
    parameter int LINE_LEN  = 32,
    parameter int VRAM_AW   = 11,
    parameter int VRAM_BASE = 0
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               rx_err,
    output logic               vram_req,
    input  logic               vram_gnt,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_data,
    output logic               vram_we,
    output logic               line_ready,
    output logic [5:0]         line_len,
    input  logic               line_ack,
    input  logic [5:0]         rd_addr,
    output logic [7:0]         rd_data,
    output logic               overflow
);

    // HOLD is carried by line_ready_q rather than by this enum, so that the
    // prefix states keep tracking F0/E0 (and shift breaks) while a line waits.
    typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_WRITE} state_t;

    state_t             state_q, state_d;
    logic               shift_q, shift_d;
    logic [5:0]         cursor_q, cursor_d;
    logic               pend_valid_q, pend_valid_d;
    logic [7:0]         pend_data_q, pend_data_d;
    logic               vram_req_q, vram_req_d;
    logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
    logic [7:0]         vram_data_q, vram_data_d;
    logic               line_ready_q, line_ready_d;
    logic [5:0]         line_len_q, line_len_d;
    logic               overflow_q, overflow_d;

    logic               buf_we;
    logic [5:0]         buf_waddr;
    logic [7:0]         buf_wdata;
    logic               proc_valid;
    logic [7:0]         proc_byte;
    logic [8:0]         ch;

    // {valid, ascii} for printable make codes; shift only affects letters.
    function automatic logic [8:0] decode_char(input logic [7:0] code, input logic shift);
        logic [4:0] n;
        logic       letter;
        n      = 5'd0;
        letter = 1'b1;
        case (code)
            8'h1C: n = 5'd0;   8'h32: n = 5'd1;   8'h21: n = 5'd2;   8'h23: n = 5'd3;
            8'h24: n = 5'd4;   8'h2B: n = 5'd5;   8'h34: n = 5'd6;   8'h33: n = 5'd7;
            8'h43: n = 5'd8;   8'h3B: n = 5'd9;   8'h42: n = 5'd10;  8'h4B: n = 5'd11;
            8'h3A: n = 5'd12;  8'h31: n = 5'd13;  8'h44: n = 5'd14;  8'h4D: n = 5'd15;
            8'h15: n = 5'd16;  8'h2D: n = 5'd17;  8'h1B: n = 5'd18;  8'h2C: n = 5'd19;
            8'h3C: n = 5'd20;  8'h2A: n = 5'd21;  8'h1D: n = 5'd22;  8'h22: n = 5'd23;
            8'h35: n = 5'd24;  8'h1A: n = 5'd25;
            default: letter = 1'b0;
        endcase
        if (letter) begin
            decode_char = {1'b1, (shift ? 8'h41 : 8'h61) + {3'b000, n}};
        end else begin
            case (code)
                8'h45: decode_char = 9'h130;  8'h16: decode_char = 9'h131;
                8'h1E: decode_char = 9'h132;  8'h26: decode_char = 9'h133;
                8'h25: decode_char = 9'h134;  8'h2E: decode_char = 9'h135;
                8'h36: decode_char = 9'h136;  8'h3D: decode_char = 9'h137;
                8'h3E: decode_char = 9'h138;  8'h46: decode_char = 9'h139;
                8'h29: decode_char = 9'h120;
                default: decode_char = 9'h000;
            endcase
        end
    endfunction

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cursor_d     = cursor_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        vram_req_d   = vram_req_q;
        vram_addr_d  = vram_addr_q;
        vram_data_d  = vram_data_q;
        line_ready_d = line_ready_q;
        line_len_d   = line_len_q;
        overflow_d   = 1'b0;
        buf_we       = 1'b0;
        buf_waddr    = cursor_q;
        buf_wdata    = 8'h00;
        proc_valid   = 1'b0;
        proc_byte    = rx_data;

        // Select which byte (if any) is interpreted this cycle. While an echo
        // is outstanding, one byte is parked; it goes first once WRITE exits.
        if (state_q == S_WRITE) begin
            if (vram_req_q && vram_gnt) begin
                vram_req_d = 1'b0;
                state_d    = S_IDLE;
            end
            if (rx_valid && !rx_err) begin
                if (pend_valid_q) begin
                    overflow_d = 1'b1;
                end else begin
                    pend_valid_d = 1'b1;
                    pend_data_d  = rx_data;
                end
            end
        end else if (rx_err) begin
            // Error collapses any prefix; a simultaneous byte is discarded.
            state_d = S_IDLE;
        end else if (pend_valid_q) begin
            proc_valid   = 1'b1;
            proc_byte    = pend_data_q;
            pend_valid_d = rx_valid;
            if (rx_valid) begin
                pend_data_d = rx_data;
            end
        end else begin
            proc_valid = rx_valid;
        end

        if (line_ready_q && line_ack) begin
            line_ready_d = 1'b0;
            cursor_d     = 6'd0;
        end

        ch = decode_char(proc_byte, shift_q);

        if (proc_valid) begin
            case (state_q)
                S_BRK: begin
                    if (proc_byte == 8'h12 || proc_byte == 8'h59) begin
                        shift_d = 1'b0;
                    end
                    state_d = S_IDLE;
                end
                S_EXT:     state_d = (proc_byte == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_EXT_BRK: state_d = S_IDLE;
                default: begin
                    if (proc_byte == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (proc_byte == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (proc_byte == 8'h12 || proc_byte == 8'h59) begin
                        shift_d = 1'b1;
                    end else if (!line_ready_q) begin
                        if (ch[8]) begin
                            if (cursor_q < 6'(LINE_LEN)) begin
                                buf_we      = 1'b1;
                                buf_wdata   = ch[7:0];
                                cursor_d    = cursor_q + 6'd1;
                                vram_req_d  = 1'b1;
                                vram_addr_d = VRAM_AW'(VRAM_BASE) + VRAM_AW'(cursor_q);
                                vram_data_d = ch[7:0];
                                state_d     = S_WRITE;
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end else if (proc_byte == 8'h66) begin
                            if (cursor_q != 6'd0) begin
                                cursor_d    = cursor_q - 6'd1;
                                vram_req_d  = 1'b1;
                                vram_addr_d = VRAM_AW'(VRAM_BASE) + VRAM_AW'(cursor_q - 6'd1);
                                vram_data_d = 8'h20;
                                state_d     = S_WRITE;
                            end
                        end else if (proc_byte == 8'h5A) begin
                            line_len_d   = cursor_q;
                            line_ready_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shift_q      <= 1'b0;
            cursor_q     <= 6'd0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 8'h00;
            vram_req_q   <= 1'b0;
            vram_addr_q  <= '0;
            vram_data_q  <= 8'h00;
            line_ready_q <= 1'b0;
            line_len_q   <= 6'd0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cursor_q     <= cursor_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            vram_req_q   <= vram_req_d;
            vram_addr_q  <= vram_addr_d;
            vram_data_q  <= vram_data_d;
            line_ready_q <= line_ready_d;
            line_len_q   <= line_len_d;
            overflow_q   <= overflow_d;
        end
    end

    // Line buffer: not reset; sized to the full 6-bit index space so rd_addr
    // can index it directly.
    logic [7:0] buf_mem [64];

    always_ff @(posedge CLK) begin
        if (buf_we) begin
            buf_mem[buf_waddr] <= buf_wdata;
        end
    end

    assign rd_data    = buf_mem[rd_addr];
    assign vram_req   = vram_req_q;
    assign vram_addr  = vram_addr_q;
    assign vram_data  = vram_data_q;
    assign vram_we    = vram_req_q & vram_gnt;
    assign line_ready = line_ready_q;
    assign line_len   = line_len_q;
    assign overflow   = overflow_q;

endmodule
